// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults, address-width helper and FSM states for the register file
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Index width for a file of nregs entries; never narrower than one bit
    function automatic int rf_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with alloc/writeback priority and read-port lookups
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int AW       = rf_aw(NREGS_DEF),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy vector: writeback releases, allocation claims afterwards so a new producer wins
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            if (enable && wb_en && wb_addr == AW'(i)) begin
                busy_d[i] = 1'b0;
            end
            if (enable && alloc_en && alloc_addr == AW'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Busy register; reset leaves every entry free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A result being written this cycle is already on rd_data when bypass is enabled, so report it ready
    for (genvar p = 0; p < NRD; p++) begin : g_lookup
        logic [AW-1:0] ra;
        logic          fwd;
        assign ra         = rd_addr[p*AW +: AW];
        assign fwd        = (BYPASS != 0) && wb_en && (wb_addr == ra);
        assign rd_busy[p] = enable && busy_q[ra] && !fwd;
    end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with clear-on-reset sequencer, write bypass and busy scoreboard
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                init_done
);

    rf_state_e       state_q;
    rf_state_e       state_d;
    logic [AW-1:0]   clr_cnt_q;
    logic [AW-1:0]   clr_cnt_d;
    logic [XLEN-1:0] mem [NREGS];
    logic            run;
    logic            wr_en;

    assign run       = (state_q == RUN);
    assign init_done = run;
    assign wr_en     = wb_en && run && !((ZERO_REG != 0) && (wb_addr == '0));

    // Sequencer state; reset restarts the full clear pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Walk every entry once while clearing, then stay in RUN until the next reset
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            INIT: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
    end

    // Storage: the clear pass owns the write port until RUN, then writeback does
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            mem[wb_addr] <= wb_data;
        end
    end

    // Read muxes: hardwired zero, then same-cycle forwarding, then stored entry
    for (genvar p = 0; p < NRD; p++) begin : g_read
        logic [AW-1:0] ra;
        logic          is_zero;
        logic          fwd;
        assign ra      = rd_addr[p*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);
        assign fwd     = (BYPASS != 0) && wb_en && run && (wb_addr == ra);
        assign rd_data[p*XLEN +: XLEN] = (!run || is_zero) ? '0 :
                                         fwd               ? wb_data :
                                                             mem[ra];
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (run),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - randomized and directed checks of reg_file_sb against a behavioural model
module tb_reg_file_sb;

    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRB = 16;
    localparam int AWB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2*AW-1:0] rd_addr;
    logic [63:0]     rd_data;
    logic [1:0]      rd_busy;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [31:0]     wb_data;
    logic            alloc_en;
    logic [AW-1:0]   alloc_addr;
    logic            init_done;

    logic [3*AWB-1:0] b_rd_addr;
    logic [95:0]      b_rd_data;
    logic [2:0]       b_rd_busy;
    logic             b_wb_en;
    logic [AWB-1:0]   b_wb_addr;
    logic [31:0]      b_wb_data;
    logic             b_alloc_en;
    logic [AWB-1:0]   b_alloc_addr;
    logic             b_init_done;

    reg_file_sb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .init_done  (init_done)
    );

    reg_file_sb #(.XLEN(32), .NREGS(NRB), .NRD(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (b_rd_addr),
        .rd_data    (b_rd_data),
        .rd_busy    (b_rd_busy),
        .wb_en      (b_wb_en),
        .wb_addr    (b_wb_addr),
        .wb_data    (b_wb_data),
        .alloc_en   (b_alloc_en),
        .alloc_addr (b_alloc_addr),
        .init_done  (b_init_done)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [NR];
    bit          m_busy [NR];
    bit          m_run;
    int          m_init_cnt;
    int          cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [AW-1:0] a, input bit we,
                                             input logic [AW-1:0] wa, input logic [31:0] wd);
        if (!m_run || a == 0) return 32'd0;
        if (we && wa == a)    return wd;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a, input bit we, input logic [AW-1:0] wa);
        if (!m_run) return 1'b0;
        return m_busy[a] && !(we && wa == a);
    endfunction

    task automatic step(input bit we, input logic [AW-1:0] wa, input logic [31:0] wd,
                        input bit ae, input logic [AW-1:0] aa,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        wb_en      = we;
        wb_addr    = wa;
        wb_data    = wd;
        alloc_en   = ae;
        alloc_addr = aa;
        rd_addr    = {r1, r0};
        @(negedge clk);
        check("rd_data0",  rd_data[31:0],  exp_data(r0, we, wa, wd));
        check("rd_data1",  rd_data[63:32], exp_data(r1, we, wa, wd));
        check("rd_busy0",  {31'd0, rd_busy[0]}, {31'd0, exp_busy(r0, we, wa)});
        check("rd_busy1",  {31'd0, rd_busy[1]}, {31'd0, exp_busy(r1, we, wa)});
        check("init_done", {31'd0, init_done},  {31'd0, m_run});
        check("b_init_done", {31'd0, b_init_done}, {31'd0, (cyc >= NRB)});
        @(posedge clk);
        if (m_run) begin
            if (we && wa != 0) m_regs[wa] = wd;
            if (we) m_busy[wa] = 1'b0;
            if (ae && aa != 0) m_busy[aa] = 1'b1;
        end else begin
            m_init_cnt++;
            if (m_init_cnt == NR) begin
                for (int i = 0; i < NR; i++) begin
                    m_regs[i] = 32'd0;
                    m_busy[i] = 1'b0;
                end
                m_run = 1'b1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic rand_step();
        logic [AW-1:0] wa;
        logic [AW-1:0] aa;
        logic [AW-1:0] r0;
        logic [AW-1:0] r1;
        wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NR - 1));
        aa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NR - 1));
        r0 = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, NR - 1));
        r1 = ($urandom_range(0, 2) == 0) ? aa : AW'($urandom_range(0, 7));
        step(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), aa, r0, r1);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("init_in_reset", {31'd0, init_done}, 32'd0);
        check("b_init_in_reset", {31'd0, b_init_done}, 32'd0);
        m_run      = 1'b0;
        m_init_cnt = 0;
        cyc        = 0;
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
        b_wb_en = 1'b0; b_wb_addr = '0; b_wb_data = '0; b_alloc_en = 1'b0; b_alloc_addr = '0;
        b_rd_addr = '0;
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
        m_run = 1'b0; m_init_cnt = 0; cyc = 0;
        #2 rst_n = 1'b0;

        // clear sequence with random traffic that must be ignored
        apply_reset();
        for (int i = 0; i < NR; i++) rand_step();
        for (int a = 0; a < NR; a++) step(1'b0, '0, '0, 1'b0, '0, AW'(a), AW'(NR - 1 - a));

        // basic write / zero register
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd0, 5'd0);
        step(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd5);
        step(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 5'd0, 5'd0);
        step(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0);

        // same-cycle bypass
        step(1'b1, 5'd9, 32'h1234, 1'b0, '0, 5'd0, 5'd9);

        // scoreboard alloc / release / simultaneous
        step(1'b0, '0, '0, 1'b1, 5'd7, 5'd0, 5'd0);
        step(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd7);
        step(1'b1, 5'd7, 32'h55, 1'b0, '0, 5'd7, 5'd0);
        step(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd7);
        step(1'b1, 5'd7, 32'h66, 1'b1, 5'd7, 5'd7, 5'd7);
        step(1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd7);
        step(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd0);

        for (int i = 0; i < 400; i++) rand_step();

        // reset mid-run restarts the clear pass
        step(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 5'd3, 5'd4);
        step(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd4);
        apply_reset();
        for (int i = 0; i < NR; i++) rand_step();
        for (int a = 0; a < NR; a++) step(1'b0, '0, '0, 1'b0, '0, AW'(a), AW'((a + 1) % NR));
        for (int i = 0; i < 100; i++) rand_step();

        // 16-entry, three-port, no-bypass instance
        b_wb_en = 1'b1; b_wb_addr = 4'd15; b_wb_data = 32'hFF;
        b_alloc_en = 1'b1; b_alloc_addr = 4'd12;
        b_rd_addr = {4'd0, 4'd15, 4'd15};
        @(negedge clk);
        check("b_nobyp_p0", b_rd_data[31:0],  32'd0);
        check("b_nobyp_p1", b_rd_data[63:32], 32'd0);
        @(posedge clk);
        #1;
        b_wb_en = 1'b1; b_wb_addr = 4'd12; b_wb_data = 32'h77; b_alloc_en = 1'b0;
        b_rd_addr = {4'd0, 4'd15, 4'd12};
        @(negedge clk);
        check("b_busy_nobyp", {29'd0, b_rd_busy}, 32'd1);
        check("b_old_val",  b_rd_data[31:0],  32'd0);
        check("b_r15_p1",   b_rd_data[63:32], 32'hFF);
        check("b_r0_p2",    b_rd_data[95:64], 32'd0);
        @(posedge clk);
        #1;
        b_wb_en = 1'b1; b_wb_addr = 4'd0; b_wb_data = 32'h99;
        b_rd_addr = {4'd0, 4'd15, 4'd15};
        @(negedge clk);
        check("b_r15_p0", b_rd_data[31:0],  32'hFF);
        check("b_r15_p1b", b_rd_data[63:32], 32'hFF);
        check("b_r0_p2b", b_rd_data[95:64], 32'd0);
        @(posedge clk);
        #1;
        b_wb_en = 1'b0;
        b_rd_addr = {4'd12, 4'd0, 4'd12};
        @(negedge clk);
        check("b_r12", b_rd_data[31:0], 32'h77);
        check("b_r0_after_wr", b_rd_data[63:32], 32'd0);
        check("b_busy_clear", {29'd0, b_rd_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
